// File: rtl/serial_fa_ctrl.sv
// Bit-serial W-bit adder: one full-adder cell reused over W cycles, LSB first.
// Define SERIAL_FA_SUB_EN to add a `sub` input that turns the operation into a - b.
module serial_fa_ctrl #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef SERIAL_FA_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  sa_q, sa_d;
    logic [W-1:0]  sb_q, sb_d;
    logic [W-1:0]  wsum_q, wsum_d;
    logic          c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;

    // Full adder from two half adders.
    logic ha1_s, ha1_c, ha2_c, fa_s, fa_c;
    always_comb begin
        ha1_s = sa_q[0] ^ sb_q[0];
        ha1_c = sa_q[0] & sb_q[0];
        fa_s  = ha1_s ^ c_q;
        ha2_c = ha1_s & c_q;
        fa_c  = ha1_c | ha2_c;
    end

    // Subtraction is a + ~b + 1; cout=1 then means no borrow.
    logic [W-1:0] b_ld;
    logic         c_ld;
`ifdef SERIAL_FA_SUB_EN
    always_comb begin
        b_ld = sub ? ~b : b;
        c_ld = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_ld = b;
        c_ld = cin;
    end
`endif

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        wsum_d  = wsum_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b_ld;
                    c_d     = c_ld;
                    cnt_d   = '0;
                    wsum_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                wsum_d = {fa_s, wsum_q[W-1:1]};
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                c_d    = fa_c;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = StDone;
                    sum_d   = wsum_d;
                    cout_d  = fa_c;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            wsum_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            wsum_q  <= wsum_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_fa_ctrl.sv
// Scoreboard bench for serial_fa_ctrl (W=4): driver pushes expected results,
// a negedge monitor pops and compares on each done pulse.
module tb_serial_fa_ctrl;
    localparam int unsigned W  = 4;
    localparam int unsigned CW = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
`ifdef SERIAL_FA_SUB_EN
    logic         sub = 1'b0;
`endif
    logic         busy, done, cout;
    logic [W-1:0] sum;

    serial_fa_ctrl #(.W(W), .CW(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_FA_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ops    = 0;
    int n_done   = 0;
    logic [W:0] exp_q[$];
    logic [W:0] last_res = '0;
    logic       mon_en = 1'b0;
    logic       rst_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                         input logic icin, input logic isub);
        int r;
        if (isub) r = int'(ia) - int'(ib) + (1 << W);
        else      r = int'(ia) + int'(ib) + int'(icin);
        return (W+1)'(r);
    endfunction

    // Monitor: results only on done, outputs otherwise hold the last result.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                rst_pending = 1'b1;
                last_res    = '0;
            end else if (rst_pending) begin
                rst_pending = 1'b0;
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_done", 64'(done), 64'd0);
                check("abort_res", 64'({cout, sum}), 64'd0);
            end else if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    last_res = exp_q.pop_front();
                    check("result", 64'({cout, sum}), 64'(last_res));
                end
            end else begin
                check("hold", 64'({cout, sum}), 64'(last_res));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                          input logic isub, input logic inject);
        @(posedge clk); #1;
        a = ia; b = ib; cin = icin; start = 1'b1;
`ifdef SERIAL_FA_SUB_EN
        sub = isub;
`endif
        exp_q.push_back(model(ia, ib, icin, isub));
        n_ops++;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        for (int i = 0; i <= int'(W); i++) begin
            @(negedge clk);
            check("busy_run", 64'(busy), 64'd1);
            check("done_timing", 64'(done), 64'(i == int'(W)));
            if (inject && i == 1) begin
                start = 1'b1;
                a = W'($urandom);
                b = W'($urandom);
                cin = 1'($urandom);
            end
            if (i == 2) start = 1'b0;
        end
        @(negedge clk);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    task automatic run_abort(input logic [W-1:0] ia, input logic [W-1:0] ib);
        @(posedge clk); #1;
        a = ia; b = ib; cin = 1'b0; start = 1'b1;
`ifdef SERIAL_FA_SUB_EN
        sub = 1'b0;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc, rs, inj;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        mon_en = 1'b1;

        run_op(4'b0111, 4'b0101, 1'b0, 1'b0, 1'b0);
        run_op(4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0);
        run_op(4'b1010, 4'b0101, 1'b1, 1'b0, 1'b0);
        run_op(4'b0011, 4'b0001, 1'b0, 1'b0, 1'b1);
        run_abort(4'b1111, 4'b1111);
        run_op(4'b0110, 4'b0011, 1'b1, 1'b0, 1'b0);
`ifdef SERIAL_FA_SUB_EN
        run_op(4'b0101, 4'b0011, 1'b0, 1'b1, 1'b0);
        run_op(4'b0011, 4'b0101, 1'b0, 1'b1, 1'b0);
`endif
        for (int n = 0; n < 40; n++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom_range(0, 1));
            inj = ($urandom_range(0, 3) == 0);
`ifdef SERIAL_FA_SUB_EN
            rs  = 1'($urandom_range(0, 1));
`else
            rs  = 1'b0;
`endif
            run_op(ra, rb, rc, rs, inj);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("done_count", 64'(n_done), 64'(n_ops));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
